// File: rtl/image_filter_engine.sv
//------------------------------------------------------------------------------
// image_filter_engine : 3x3 edge-replicating neighbourhood filter, RAM to RAM
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module image_filter_engine #(
    parameter int IMG_W   = 160,
    parameter int IMG_H   = 120,
    parameter int CH_BITS = 8,
    parameter int NUM_CH  = 3,
    parameter int ADDR_W  = 15,
    localparam int PIX_W  = NUM_CH * CH_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_process,
    input  logic              abort,
    input  logic [1:0]        mode,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              write_enable,
    input  logic              wr_ready,
    output logic              processing_active,
    output logic              processing_done
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int SW = CH_BITS + 4;
    localparam logic [XW-1:0] XMAX = XW'(IMG_W - 1);
    localparam logic [YW-1:0] YMAX = YW'(IMG_H - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CALC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          k_q;
    logic [XW-1:0]       x_q, tx;
    logic [YW-1:0]       y_q, ty;
    logic [1:0]          mode_q;
    logic [PIX_W-1:0]    w_q [9];
    logic [PIX_W-1:0]    w_res;
    logic [ADDR_W-1:0]   rd_addr_q, wr_addr_q;
    logic [PIX_W-1:0]    wr_data_q;
    logic                we_q, active_q, done_q;
    logic                w_last;

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [XW-1:0] px,
                                                   input logic [YW-1:0] py);
        return ADDR_W'(py) + ADDR_W'(px) * ADDR_W'(IMG_H);
    endfunction

    assign w_last = (x_q == XMAX) && (y_q == YMAX);

    // Tap k sits at (x + k%3 - 1, y + k/3 - 1), clamped to the image.
    always_comb begin
        tx = x_q;
        ty = y_q;
        case (k_q)
            4'd0, 4'd3, 4'd6: tx = (x_q == '0)   ? x_q : x_q - XW'(1);
            4'd2, 4'd5, 4'd8: tx = (x_q == XMAX) ? x_q : x_q + XW'(1);
            default: ;
        endcase
        if (k_q <= 4'd2)
            ty = (y_q == '0) ? y_q : y_q - YW'(1);
        else if (k_q >= 4'd6 && k_q <= 4'd8)
            ty = (y_q == YMAX) ? y_q : y_q + YW'(1);
    end

    assign rd_addr = (state_q == S_READ && k_q <= 4'd8) ? pix_addr(tx, ty) : rd_addr_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam int HI = PIX_W - 1 - c * CH_BITS;
        logic [SW-1:0]      t [9];
        logic [SW-1:0]      gs, sh;
        logic [CH_BITS-1:0] res;

        for (genvar i = 0; i < 9; i++) begin : g_tap
            assign t[i] = SW'(w_q[i][HI -: CH_BITS]);
        end

        assign gs = t[0] + t[2] + t[6] + t[8]
                  + ((t[1] + t[3] + t[5] + t[7]) << 1) + (t[4] << 2);
        // Wraps modulo 2**SW; the MSB is then the sign of the true result.
        assign sh = (t[4] << 2) + t[4] - (t[1] + t[3] + t[5] + t[7]);

        always_comb begin
            res = t[4][CH_BITS-1:0];
            case (mode_q)
                2'd1: res = gs[SW-1:4];
                2'd2: begin
                    if (sh[SW-1])
                        res = '0;
                    else if (|sh[SW-2:CH_BITS])
                        res = '1;
                    else
                        res = sh[CH_BITS-1:0];
                end
                default: ;
            endcase
        end

        assign w_res[HI -: CH_BITS] = res;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_process) state_d = S_READ;
            S_READ:  if (k_q == 4'd9) state_d = S_CALC;
            S_CALC:  state_d = S_WRITE;
            S_WRITE: if (wr_ready) state_d = w_last ? S_DONE : S_READ;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (state_q == S_READ && k_q != 4'd0 && k_q <= 4'd9)
            w_q[k_q - 4'd1] <= rd_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_q       <= '0;
            x_q       <= '0;
            y_q       <= '0;
            mode_q    <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            we_q      <= 1'b0;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_process && !abort) begin
                        mode_q   <= mode;
                        x_q      <= '0;
                        y_q      <= '0;
                        k_q      <= '0;
                        active_q <= 1'b1;
                        done_q   <= 1'b0;
                    end
                end
                S_READ: begin
                    rd_addr_q <= rd_addr;
                    k_q       <= k_q + 4'd1;
                end
                S_CALC: begin
                    wr_data_q <= w_res;
                    wr_addr_q <= pix_addr(x_q, y_q);
                    we_q      <= 1'b1;
                    k_q       <= '0;
                end
                S_WRITE: begin
                    if (wr_ready) begin
                        we_q <= 1'b0;
                        if (w_last) begin
                            active_q <= 1'b0;
                            done_q   <= 1'b1;
                        end else if (x_q == XMAX) begin
                            x_q <= '0;
                            y_q <= y_q + YW'(1);
                        end else begin
                            x_q <= x_q + XW'(1);
                        end
                    end
                end
                default: ;
            endcase
            if (abort) begin
                we_q     <= 1'b0;
                active_q <= 1'b0;
            end
        end
    end

    assign wr_addr           = wr_addr_q;
    assign wr_data           = wr_data_q;
    assign write_enable      = we_q;
    assign processing_active = active_q;
    assign processing_done   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_image_filter_engine.sv
//------------------------------------------------------------------------------
// tb_image_filter_engine : directed bench on a 4x3 image with a 1-cycle RAM
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_image_filter_engine;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = 15;
    localparam int PW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_process = 1'b0;
    logic          abort = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [AW-1:0] rd_addr;
    logic [PW-1:0] rd_data = '0;
    logic [AW-1:0] wr_addr;
    logic [PW-1:0] wr_data;
    logic          write_enable;
    logic          wr_ready = 1'b1;
    logic          processing_active;
    logic          processing_done;

    image_filter_engine #(
        .IMG_W(W), .IMG_H(H), .CH_BITS(8), .NUM_CH(3), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .start_process(start_process), .abort(abort),
        .mode(mode), .rd_addr(rd_addr), .rd_data(rd_data), .wr_addr(wr_addr),
        .wr_data(wr_data), .write_enable(write_enable), .wr_ready(wr_ready),
        .processing_active(processing_active), .processing_done(processing_done)
    );

    always #5 clk = ~clk;

    logic [PW-1:0] mem [16];
    always @(posedge clk) rd_data <= mem[rd_addr[3:0]];

    int            n_tests = 0;
    int            n_fail  = 0;
    int            nw = 0;
    logic [AW-1:0] wa_log [32];
    logic [PW-1:0] wd_log [32];
    int            stall_seen = 0;
    int            stall_bad  = 0;
    logic [AW-1:0] st_a;
    logic [PW-1:0] st_d;
    int            stall_idx = -1;
    int            stall_len = 0;
    int            stall_cnt = 0;

    always @(negedge clk) begin
        if (write_enable && wr_ready) begin
            if (nw < 32) begin
                wa_log[nw] = wr_addr;
                wd_log[nw] = wr_data;
            end
            nw = nw + 1;
        end else if (write_enable && !wr_ready) begin
            if (stall_seen == 0) begin
                st_a = wr_addr;
                st_d = wr_data;
            end else if (wr_addr != st_a || wr_data != st_d) begin
                stall_bad = stall_bad + 1;
            end
            stall_seen = stall_seen + 1;
        end
    end

    always @(posedge clk) begin
        #1;
        if (write_enable && nw == stall_idx && stall_cnt < stall_len) begin
            wr_ready  = 1'b0;
            stall_cnt = stall_cnt + 1;
        end else begin
            wr_ready = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] ramp(input int x, input int y);
        return {8'(x), 8'(y), 8'(x + y)};
    endfunction

    task automatic load_ramp();
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++)
                mem[y + x * H] = ramp(x, y);
    endtask

    task automatic load_fill(input logic [PW-1:0] bg, input logic [PW-1:0] ctr);
        for (int i = 0; i < 16; i++) mem[i] = bg;
        mem[1 + 1 * H] = ctr;
    endtask

    int cyc;
    bit act1, done1, act_done, seen;

    task automatic run_frame(input logic [1:0] m, input bit hold);
        nw   = 0;
        mode = m;
        @(posedge clk); #1 start_process = 1'b1;
        @(posedge clk); #1 if (!hold) start_process = 1'b0;
        cyc = 0; seen = 0; act1 = 0; done1 = 0; act_done = 0;
        while (!seen && cyc < 1000) begin
            @(negedge clk);
            cyc = cyc + 1;
            if (cyc == 1) begin
                act1  = processing_active;
                done1 = processing_done;
            end
            if (processing_done) begin
                seen     = 1;
                act_done = processing_active;
            end
        end
    endtask

    initial begin
        int dh;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        // Reset state
        #12;
        check("rst_we",     32'(write_enable), 32'd0);
        check("rst_active", 32'(processing_active), 32'd0);
        check("rst_done",   32'(processing_done), 32'd0);
        check("rst_wraddr", 32'(wr_addr), 32'd0);
        check("rst_rdaddr", 32'(rd_addr), 32'd0);
        @(posedge clk); #1 rst = 1'b1;

        // 1: copy of ramp image, scan order and frame latency
        load_ramp();
        run_frame(2'd0, 1'b0);
        check("t1_done_seen", 32'(seen), 32'd1);
        check("t1_active_start", 32'(act1), 32'd1);
        check("t1_done_start", 32'(done1), 32'd0);
        check("t1_latency", 32'(cyc), 32'd145);
        check("t1_active_at_done", 32'(act_done), 32'd0);
        check("t1_nwrites", 32'(nw), 32'd12);
        for (int n = 0; n < 12; n++) begin
            check($sformatf("t1_addr%0d", n), 32'(wa_log[n]), 32'((n / W) + (n % W) * H));
            check($sformatf("t1_data%0d", n), 32'(wd_log[n]), 32'(ramp(n % W, n / W)));
        end

        // 2: gaussian, bright centre pixel on flat background
        load_fill(24'h404040, 24'hF0F0F0);
        run_frame(2'd1, 1'b0);
        check("t2_nwrites", 32'(nw), 32'd12);
        check("t2_p11", 32'(wd_log[5]),  32'h6C6C6C);  // (256+512+960)/16 = 108
        check("t2_p00", 32'(wd_log[0]),  32'h4B4B4B);  // 1200/16 = 75
        check("t2_p10", 32'(wd_log[1]),  32'h565656);  // 1376/16 = 86
        check("t2_p32", 32'(wd_log[11]), 32'h404040);

        // 3: sharpen, positive and negative clamps
        load_fill(24'h800000, 24'hFF00FF);
        run_frame(2'd2, 1'b0);
        check("t3_nwrites", 32'(nw), 32'd12);
        check("t3_p11", 32'(wd_log[5]), 32'hFF00FF);
        check("t3_p10", 32'(wd_log[1]), 32'h010000);
        check("t3_p21", 32'(wd_log[6]), 32'h010000);
        check("t3_p00", 32'(wd_log[0]), 32'h800000);

        // 4: back-pressure on the third write, mode 3 behaves as copy
        load_ramp();
        stall_seen = 0; stall_bad = 0; stall_cnt = 0;
        stall_len = 5; stall_idx = 2;
        run_frame(2'd3, 1'b0);
        stall_idx = -1;
        check("t4_done_seen", 32'(seen), 32'd1);
        check("t4_latency", 32'(cyc), 32'd150);
        check("t4_nwrites", 32'(nw), 32'd12);
        check("t4_stall_cycles", 32'(stall_seen), 32'd5);
        check("t4_stall_stable", 32'(stall_bad), 32'd0);
        check("t4_stall_addr", 32'(st_a), 32'd6);
        check("t4_addr2", 32'(wa_log[2]), 32'd6);
        check("t4_data2", 32'(wd_log[2]), 32'h020002);
        check("t4_data3", 32'(wd_log[3]), 32'h030003);

        // 5: abort during READ of pixel 5, then a clean full frame
        nw = 0; mode = 2'd0;
        @(posedge clk); #1 start_process = 1'b1;
        @(posedge clk); #1 start_process = 1'b0;
        for (int i = 0; i < 200 && nw < 5; i++) @(negedge clk);
        check("t5_reached5", 32'(nw), 32'd5);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("t5_active", 32'(processing_active), 32'd0);
        check("t5_we", 32'(write_enable), 32'd0);
        check("t5_done", 32'(processing_done), 32'd0);
        repeat (40) @(negedge clk);
        check("t5_no_more_writes", 32'(nw), 32'd5);
        check("t5_still_idle", 32'(processing_active), 32'd0);
        run_frame(2'd0, 1'b0);
        check("t5_restart_seen", 32'(seen), 32'd1);
        check("t5_restart_nw", 32'(nw), 32'd12);
        check("t5_restart_first", 32'(wa_log[0]), 32'd0);
        check("t5_restart_last", 32'(wa_log[11]), 32'd11);
        check("t5_restart_d5", 32'(wd_log[5]), 32'(ramp(1, 1)));

        // 6: async reset mid-WRITE, then back-to-back frames with start held
        nw = 0; stall_cnt = 0; stall_len = 100; stall_idx = 5;
        @(posedge clk); #1 start_process = 1'b1;
        @(posedge clk); #1 start_process = 1'b0;
        for (int i = 0; i < 200 && !(write_enable && nw == 5); i++) @(negedge clk);
        check("t6_in_write", 32'(write_enable), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("t6_rst_we", 32'(write_enable), 32'd0);
        check("t6_rst_active", 32'(processing_active), 32'd0);
        check("t6_rst_done", 32'(processing_done), 32'd0);
        check("t6_rst_wraddr", 32'(wr_addr), 32'd0);
        check("t6_rst_wrdata", 32'(wr_data), 32'd0);
        check("t6_rst_rdaddr", 32'(rd_addr), 32'd0);
        stall_idx = -1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        run_frame(2'd0, 1'b1);
        check("t6_f1_seen", 32'(seen), 32'd1);
        check("t6_f1_latency", 32'(cyc), 32'd145);
        dh = 0;
        while (processing_done && dh < 10) begin
            dh = dh + 1;
            @(negedge clk);
        end
        check("t6_done_cycles", 32'(dh), 32'd2);
        check("t6_f2_active", 32'(processing_active), 32'd1);
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (processing_done) seen = 1;
        end
        check("t6_f2_seen", 32'(seen), 32'd1);
        check("t6_f2_nwrites", 32'(nw), 32'd24);
        check("t6_f2_addr13", 32'(wa_log[13]), 32'd3);
        start_process = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
